// File: rtl/g_sched_pkg.sv
// Shared types and constants for the G-matrix scheduler.
// The optional S_WAIT watchdog is enabled by defining G_SCHED_WATCHDOG_EN.
package g_sched_pkg;

  localparam int N          = 16;
  localparam int Q_MAX      = 16;
  localparam int ADDR_W     = 7;
  localparam int QW         = 4;
  localparam int WD_LIMIT   = 64;

  localparam int HQ_ELEMS   = 8;
  localparam int G_ROWS     = 4;
  localparam int LOAD_BEATS = 9;
  localparam int BEAT_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_LOAD = 3'd2,
    S_WAIT = 3'd3,
    S_FIN  = 3'd4
  } g_state_e;

  // Hq buffer is row-major per candidate: element k of candidate q lives at q*8 + k.
  function automatic logic [ADDR_W-1:0] hq_addr(input logic [QW-1:0] q,
                                                input logic [2:0]    k);
    return ADDR_W'(q) * ADDR_W'(HQ_ELEMS) + ADDR_W'(k);
  endfunction

endpackage

// File: rtl/g_matrix_scheduler_if.sv
// Hq buffer read port, calculator stream and G-row tag bundle of the scheduler.
// Uses g_sched_pkg for widths.
interface g_matrix_scheduler_if;
  import g_sched_pkg::*;

  // No backpressure anywhere on this bundle: mem_rd_en is answered one cycle later,
  // hq_valid/calc_row_valid/calc_done are single-cycle qualifiers that are always consumed.
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [N-1:0]      mem_rd_r;
  logic [N-1:0]      mem_rd_i;
  logic              hq_valid;
  logic [N-1:0]      hq_r;
  logic [N-1:0]      hq_i;
  logic              calc_row_valid;
  logic              calc_done;
  logic [QW-1:0]     g_q_idx;
  logic [1:0]        g_row_idx;

  modport master (
    output mem_rd_en, mem_rd_addr, hq_valid, hq_r, hq_i, g_q_idx, g_row_idx,
    input  mem_rd_r, mem_rd_i, calc_row_valid, calc_done
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, hq_valid, hq_r, hq_i, g_q_idx, g_row_idx,
    output mem_rd_r, mem_rd_i, calc_row_valid, calc_done
  );

endinterface

// File: rtl/g_sched_addr_gen.sv
// Load-phase beat counter, Hq address mux and the 1-cycle read-data valid delay.
module g_sched_addr_gen
  import g_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [QW-1:0]     q,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              hq_valid,
  output logic              last_beat
);

  logic [BEAT_W-1:0] beat;
  logic [2:0]        elem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (load_en && !last_beat) begin
      beat <= beat + BEAT_W'(1);
    end else begin
      beat <= '0;
    end
  end

  // Read data arrives one cycle after the strobe, so valid trails it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hq_valid <= 1'b0;
    end else begin
      hq_valid <= rd_en;
    end
  end

  // Beat 0 wakes the calculator, so element 0 is fetched twice.
  assign elem      = (beat == '0) ? 3'd0 : 3'(beat - BEAT_W'(1));
  assign rd_en     = load_en;
  assign rd_addr   = hq_addr(q, elem);
  assign last_beat = (beat == BEAT_W'(LOAD_BEATS - 1));

endmodule

// File: rtl/g_matrix_scheduler.sv
// Sequences the G-matrix calculator over num_q candidate Hq matrices and tags its rows.
// Define G_SCHED_WATCHDOG_EN to abort a run when calc_done does not arrive within WD_LIMIT cycles.
module g_matrix_scheduler
  import g_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [QW:0]           num_q,
  input  logic                  ds_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output g_state_e              state_dbg,
  g_matrix_scheduler_if.master  bus
);

  localparam logic [QW:0] Q_MAX_V = (QW+1)'(Q_MAX);

  g_state_e      state, state_nx;
  logic [QW-1:0] q;
  logic [QW:0]   num_q_r;
  logic [QW:0]   num_q_clamped;
  logic [2:0]    row_cnt;
  logic [2:0]    row_total;
  logic          start_acc;
  logic          last_q;
  logic          rows_bad;
  logic          stray_row;
  logic          wd_expire;
  logic          load_en;
  logic          last_beat;
  logic          rd_en_w;
  logic [ADDR_W-1:0] rd_addr_w;
  logic          hq_valid_w;

  assign num_q_clamped = (num_q > Q_MAX_V) ? Q_MAX_V : num_q;
  assign start_acc     = (state == S_IDLE) && start;
  assign last_q        = ({1'b0, q} == (num_q_r - (QW+1)'(1)));
  assign row_total     = row_cnt + {2'b00, bus.calc_row_valid};
  assign rows_bad      = bus.calc_done && (row_total != 3'(G_ROWS));
  assign stray_row     = bus.calc_row_valid && (state != S_WAIT);
  assign load_en       = (state == S_LOAD);

`ifdef G_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  // wd_cnt is 0 on the S_WAIT entry cycle, so S_FIN lands exactly WD_LIMIT cycles later.
  assign wd_expire = (state == S_WAIT) && !bus.calc_done && (wd_cnt == WD_W'(WD_LIMIT - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = (num_q_clamped == '0) ? S_FIN : S_ARM;
      S_ARM:  if (ds_ready) state_nx = S_LOAD;
      S_LOAD: if (last_beat) state_nx = S_WAIT;
      S_WAIT: begin
        if (bus.calc_done) begin
          state_nx = last_q ? S_FIN : S_ARM;
        end else if (wd_expire) begin
          state_nx = S_FIN;
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      num_q_r <= '0;
    end else if (start_acc) begin
      q       <= '0;
      num_q_r <= num_q_clamped;
    end else if ((state == S_WAIT) && bus.calc_done && !last_q) begin
      q <= q + QW'(1);
    end
  end

  // Row counter saturates so a runaway calculator cannot alias back to a legal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
    end else if ((state != S_WAIT) || bus.calc_done) begin
      row_cnt <= '0;
    end else if (bus.calc_row_valid && (row_cnt != 3'd7)) begin
      row_cnt <= row_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start_acc) begin
      err <= 1'b0;
    end else if (stray_row || ((state == S_WAIT) && rows_bad) || wd_expire) begin
      err <= 1'b1;
    end
  end

  g_sched_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .q         (q),
    .rd_en     (rd_en_w),
    .rd_addr   (rd_addr_w),
    .hq_valid  (hq_valid_w),
    .last_beat (last_beat)
  );

  assign bus.mem_rd_en   = rd_en_w;
  assign bus.mem_rd_addr = rd_addr_w;
  assign bus.hq_valid    = hq_valid_w;
  assign bus.hq_r        = bus.mem_rd_r;
  assign bus.hq_i        = bus.mem_rd_i;
  assign bus.g_q_idx     = q;
  assign bus.g_row_idx   = row_cnt[1:0];

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign state_dbg = state;

endmodule

// File: doc/g_matrix_scheduler.md
Name: g_matrix_scheduler

Overview:
Sequences the G-matrix calculator over Q candidate channel matrices Hq, one per antenna-combination index q.
- Fetches each 8-element complex Hq (row-major, 4x2) from the Hq buffer and streams it to the calculator.
- Waits for the calculator's done, then advances q.
- Tags each G row with its q index and row index for the downstream metric unit.
- Gates each launch on downstream readiness, because the calculator has no backpressure.

Parameters:
N, 16, real/imag sample width
Q_MAX, 16, maximum number of Hq candidates
ADDR_W, 7, Hq buffer address width, = clog2(Q_MAX*8)
QW, 4, q index width, = clog2(Q_MAX)
WD_LIMIT, 64, watchdog cycle limit in S_WAIT (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse; begins a run; ignored while busy
num_q  in  QW+1  candidates in this run; sampled on start; values > Q_MAX are clamped to Q_MAX
ds_ready  in  1  downstream can accept 4 G rows
mem_rd_en  out  1  Hq buffer read strobe
mem_rd_addr  out  ADDR_W  Hq buffer address (q*8 + k)
mem_rd_r / mem_rd_i  in  N each  read data, returned 1 cycle after mem_rd_en
hq_valid  out  1  to calculator Hq_in_valid
hq_r / hq_i  out  N each  to calculator Hq_in_r / Hq_in_i
calc_row_valid  in  1  from calculator G_row_valid
calc_done  in  1  from calculator done
g_q_idx  out  QW  q of the rows currently emitted
g_row_idx  out  2  row index (0..3) of the current calc_row_valid beat
busy  out  1  a run is in progress
done  out  1  1-cycle pulse at end of run
err  out  1  sticky error flag; cleared by start

Behaviour:
- Reset values: all outputs 0; state S_IDLE; q = 0; beat counter = 0; row counter = 0.
- State S_IDLE:
  - On start, latch the clamped num_q and clear err.
  - If num_q == 0, go to S_FIN (done pulses on the next cycle, no reads issued).
  - Otherwise go to S_ARM with q = 0.
- State S_ARM: wait for ds_ready == 1, then go to S_LOAD.
  - ds_ready is sampled only here; it is ignored during S_LOAD and S_WAIT.
- State S_LOAD: 9 consecutive cycles, beat counter b = 0..8.
  - mem_rd_en = 1; mem_rd_addr = q*8 + (b == 0 ? 0 : b-1).
  - Beat 0 is a wake beat: the calculator consumes its first valid beat as an IDLE->LOADING trigger without storing it. Element 0 is therefore sent twice.
  - After b = 8, go to S_WAIT.
- Data path to calculator: hq_valid = mem_rd_en delayed 1 cycle; hq_r/hq_i = mem_rd_r/mem_rd_i, unregistered. hq_valid is low on every cycle outside these 9 beats.
- State S_WAIT:
  - Count calc_row_valid beats; g_row_idx = count before increment.
  - On calc_done, count rows including a row beat in the same cycle. If total != 4, set err.
  - Then, if q == num_q-1, go to S_FIN; else q++ and go to S_ARM.
- State S_FIN: done = 1 for one cycle, then S_IDLE.
- busy = 1 in every state except S_IDLE.
- g_q_idx holds q, stable from S_LOAD entry through the calc_done cycle.
- Timing with ds_ready held high (S_ARM at cycle 0):
  - rd_en on cycles 1..9; hq_valid on cycles 2..10.
  - calc_row_valid on cycles 12..15; calc_done on cycle 15.
  - Next S_ARM at cycle 16, giving a 16-cycle launch-to-launch interval.
- Boundary conditions:
  - start during busy: ignored.
  - calc_row_valid outside S_WAIT: ignored and sets err.
  - rst mid-run: returns to S_IDLE immediately, no done pulse; the calculator shares rst.
  - q wrap: none; q never exceeds num_q-1.

Optional Feature:
Macro G_SCHED_WATCHDOG_EN.
- Defined: a counter runs in S_WAIT. If WD_LIMIT cycles pass without calc_done, the block sets err and goes to S_FIN, aborting the remaining candidates and pulsing done.
- Undefined: no counter; S_WAIT waits indefinitely; WD_LIMIT is unused.

Decomposition:
- Shared package g_sched_pkg holds:
  - state encoding (S_IDLE, S_ARM, S_LOAD, S_WAIT, S_FIN);
  - HQ_ELEMS = 8, G_ROWS = 4, LOAD_BEATS = 9 constants;
  - the address-generation function q*HQ_ELEMS + k.
- One natural sub-module: g_sched_addr_gen (beat counter plus address mux plus 1-cycle valid delay).
- The FSM, row checker and tags stay in the top module.

Test Plan:
- start, num_q=1, ds_ready=1, buffer[i]=i+1 -> reads at addr 0,0,1..7; 9 hq_valid beats; done on cycle 16 after start; err=0; calculator outputs row 0: Ga1=(1,2).
- num_q=3, ds_ready=1 -> launches exactly 16 cycles apart; g_q_idx = 0,1,2 across the three row groups; g_row_idx = 0..3 in each group; single done pulse.
- num_q=2, ds_ready low for 10 cycles before the second launch -> block holds in S_ARM with mem_rd_en=0, then resumes; total run takes 10 cycles longer.
- num_q=0 -> done on the cycle after start; mem_rd_en never asserted. num_q=20 -> clamped to 16 runs; last address 127.
- Stubbed calculator that emits only 3 rows before done -> err=1; it stays set until the next start clears it. rst asserted mid-S_LOAD -> all outputs 0 and no done pulse.
- With G_SCHED_WATCHDOG_EN and a stub that never asserts done -> err=1 and done exactly WD_LIMIT cycles after S_WAIT entry.
